// File: rtl/mole_hit_judge_if.sv
// rtl/mole_hit_judge_if.sv - mole position generator <-> hit judge handshake
interface mole_hit_judge_if;
    logic [2:0] mole_position;
    logic       position_changed;
    logic       change_position;

    modport master (
        output mole_position,
        output position_changed,
        input  change_position
    );

    modport slave (
        input  mole_position,
        input  position_changed,
        output change_position
    );
endinterface

// File: rtl/mole_hit_judge.sv
// rtl/mole_hit_judge.sv - whack-a-mole hit/miss judge with BCD score and game-over
module mole_hit_judge #(
    parameter int MAX_MISSES     = 10,
    parameter bit ESCAPE_IS_MISS = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mole_hit_judge_if.slave     gen,
    input  logic [4:0]          i_btn,
    output logic                o_hit,
    output logic                o_miss,
    output logic [3:0]          o_score_tens,
    output logic [3:0]          o_score_ones,
    output logic [3:0]          o_miss_count,
    output logic                o_game_over
);
    typedef enum logic [1:0] {IDLE, ARMED, WAIT_NEW, OVER} state_t;

    state_t     state, state_d;
    logic [2:0] pos_q;
    logic [4:0] btn_q;
    logic [4:0] press;
    logic [4:0] target;
    logic       new_valid;
    logic       last_miss;
    logic       score_full;
    logic       hit_d, miss_d, chg_d;

    assign press      = i_btn & ~btn_q;
    assign target     = 5'd1 << pos_q;
    assign new_valid  = (gen.mole_position <= 3'd4);
    assign last_miss  = (o_miss_count == 4'(MAX_MISSES - 1));
    assign score_full = (o_score_tens == 4'd9) && (o_score_ones == 4'd9);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= IDLE;
            pos_q               <= 3'd5;
            btn_q               <= 5'b11111;
            o_hit               <= 1'b0;
            o_miss              <= 1'b0;
            gen.change_position <= 1'b0;
            o_score_tens        <= 4'd0;
            o_score_ones        <= 4'd0;
            o_miss_count        <= 4'd0;
            o_game_over         <= 1'b0;
        end else begin
            state               <= state_d;
            btn_q               <= i_btn;
            o_hit               <= hit_d;
            o_miss              <= miss_d;
            gen.change_position <= chg_d;
            o_game_over         <= (state_d == OVER);
            if (gen.position_changed && state != OVER)
                pos_q <= gen.mole_position;
            if (hit_d && !score_full) begin
                if (o_score_ones == 4'd9) begin
                    o_score_ones <= 4'd0;
                    o_score_tens <= o_score_tens + 4'd1;
                end else begin
                    o_score_ones <= o_score_ones + 4'd1;
                end
            end
            if (miss_d && o_miss_count != 4'(MAX_MISSES))
                o_miss_count <= o_miss_count + 4'd1;
        end
    end

    // A press coinciding with a strobe is judged against the old position.
    always_comb begin
        hit_d  = 1'b0;
        miss_d = 1'b0;
        chg_d  = 1'b0;
        if (state == ARMED) begin
            if (press != 5'd0 && press == target) begin
                hit_d = 1'b1;
                chg_d = ~gen.position_changed;
            end else if (press != 5'd0) begin
                miss_d = 1'b1;
            end else if (gen.position_changed) begin
                miss_d = ESCAPE_IS_MISS;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:
                if (gen.position_changed && new_valid) state_d = ARMED;
            ARMED: begin
                if (gen.position_changed) state_d = new_valid ? ARMED : IDLE;
                else if (hit_d)           state_d = WAIT_NEW;
                if (miss_d && last_miss)  state_d = OVER;
            end
            WAIT_NEW:
                if (gen.position_changed) state_d = new_valid ? ARMED : IDLE;
            default:
                state_d = OVER;
        endcase
    end
endmodule

// File: tb/tb_mole_hit_judge.sv
// tb/tb_mole_hit_judge.sv - scoreboard bench for mole_hit_judge
module tb_mole_hit_judge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = 5'd0;
    logic       hit, miss, game_over;
    logic [3:0] tens, ones, misses;
    int         checks = 0;
    int         fails  = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [4:0]  b;
        logic        s;
        logic [2:0]  p;
        logic [15:0] e;
    } step_t;

    mole_hit_judge_if bus ();

    mole_hit_judge #(.MAX_MISSES(10), .ESCAPE_IS_MISS(1'b1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .gen          (bus.slave),
        .i_btn        (btn),
        .o_hit        (hit),
        .o_miss       (miss),
        .o_score_tens (tens),
        .o_score_ones (ones),
        .o_miss_count (misses),
        .o_game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] obs();
        return {hit, miss, bus.change_position, tens, ones, misses, game_over};
    endfunction

    function automatic logic [15:0] ev(bit h, bit m, bit c, int sc, int mc, bit go);
        return {h, m, c, 4'(sc / 10), 4'(sc % 10), 4'(mc), go};
    endfunction

    task automatic drive(input logic [4:0] b, input logic s, input logic [2:0] p,
                         input logic [15:0] e);
        btn = b;
        bus.position_changed = s;
        bus.mole_position = p;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.position_changed = 1'b0;
    endtask

    task automatic apply_reset(input logic [4:0] b);
        btn = b;
        rst = 1'b1;
        bus.position_changed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 16'd0) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h", obs(), 16'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.mole_position = 3'd0;
        apply_reset(5'b11111);
        sb_q.push_back(ev(0, 0, 0, 0, 0, 0));
        btn = 5'd0;
        @(posedge clk); #1;
        checks++;
        if (obs() !== sb_q[0]) begin
            fails++;
            $display("FAIL reset_idle: got %h expected %h", obs(), sb_q[0]);
        end
        void'(sb_q.pop_front());
    endtask

    task automatic test_hit_and_miss();
        step_t st[$];
        logic [15:0] exp;
        st.push_back('{5'b00000, 1'b1, 3'd2, ev(0, 0, 0, 0, 0, 0)});
        st.push_back('{5'b00100, 1'b0, 3'd2, ev(1, 0, 1, 1, 0, 0)});
        st.push_back('{5'b00100, 1'b0, 3'd2, ev(0, 0, 0, 1, 0, 0)});
        st.push_back('{5'b00000, 1'b0, 3'd2, ev(0, 0, 0, 1, 0, 0)});
        st.push_back('{5'b00100, 1'b0, 3'd2, ev(0, 0, 0, 1, 0, 0)});
        st.push_back('{5'b00000, 1'b1, 3'd1, ev(0, 0, 0, 1, 0, 0)});
        st.push_back('{5'b01000, 1'b0, 3'd1, ev(0, 1, 0, 1, 1, 0)});
        st.push_back('{5'b00000, 1'b0, 3'd1, ev(0, 0, 0, 1, 1, 0)});
        st.push_back('{5'b10010, 1'b0, 3'd1, ev(0, 1, 0, 1, 2, 0)});
        st.push_back('{5'b00000, 1'b0, 3'd1, ev(0, 0, 0, 1, 2, 0)});
        foreach (st[i]) begin
            drive(st[i].b, st[i].s, st[i].p, st[i].e);
            exp = sb_q.pop_front();
            checks++;
            if (obs() !== exp) begin
                fails++;
                $display("FAIL hit_miss step %0d: got %h expected %h", i, obs(), exp);
            end
        end
    endtask

    task automatic test_held_and_simultaneous();
        step_t st[$];
        logic [15:0] exp;
        apply_reset(5'b00001);
        st.push_back('{5'b00001, 1'b1, 3'd0, ev(0, 0, 0, 0, 0, 0)});
        st.push_back('{5'b00001, 1'b0, 3'd0, ev(0, 0, 0, 0, 0, 0)});
        st.push_back('{5'b00000, 1'b0, 3'd0, ev(0, 0, 0, 0, 0, 0)});
        st.push_back('{5'b00001, 1'b0, 3'd0, ev(1, 0, 1, 1, 0, 0)});
        st.push_back('{5'b00000, 1'b1, 3'd4, ev(0, 0, 0, 1, 0, 0)});
        st.push_back('{5'b10000, 1'b1, 3'd0, ev(1, 0, 0, 2, 0, 0)});
        st.push_back('{5'b00000, 1'b0, 3'd0, ev(0, 0, 0, 2, 0, 0)});
        st.push_back('{5'b00001, 1'b0, 3'd0, ev(1, 0, 1, 3, 0, 0)});
        st.push_back('{5'b00000, 1'b1, 3'd3, ev(0, 0, 0, 3, 0, 0)});
        st.push_back('{5'b00000, 1'b1, 3'd6, ev(0, 1, 0, 3, 1, 0)});
        st.push_back('{5'b01000, 1'b0, 3'd6, ev(0, 0, 0, 3, 1, 0)});
        foreach (st[i]) begin
            drive(st[i].b, st[i].s, st[i].p, st[i].e);
            exp = sb_q.pop_front();
            checks++;
            if (obs() !== exp) begin
                fails++;
                $display("FAIL held_simul step %0d: got %h expected %h", i, obs(), exp);
            end
        end
    endtask

    task automatic test_score_saturation();
        logic [15:0] exp;
        apply_reset(5'b00000);
        drive(5'b00000, 1'b1, 3'd0, ev(0, 0, 0, 0, 0, 0));
        void'(sb_q.pop_front());
        for (int n = 1; n <= 100; n++) begin
            drive(5'b00001, 1'b0, 3'd0, ev(1, 0, 1, (n > 99) ? 99 : n, 0, 0));
            exp = sb_q.pop_front();
            checks++;
            if (obs() !== exp) begin
                fails++;
                $display("FAIL score_hit %0d: got %h expected %h", n, obs(), exp);
            end
            drive(5'b00000, 1'b1, 3'd0, ev(0, 0, 0, (n > 99) ? 99 : n, 0, 0));
            exp = sb_q.pop_front();
            checks++;
            if (obs() !== exp) begin
                fails++;
                $display("FAIL score_relatch %0d: got %h expected %h", n, obs(), exp);
            end
        end
    endtask

    task automatic test_game_over();
        step_t st[$];
        logic [15:0] exp;
        apply_reset(5'b00000);
        st.push_back('{5'b00000, 1'b1, 3'd0, ev(0, 0, 0, 0, 0, 0)});
        for (int i = 1; i <= 10; i++)
            st.push_back('{5'b00000, 1'b1, 3'(i % 5), ev(0, 1, 0, 0, i, i == 10)});
        st.push_back('{5'b00010, 1'b1, 3'd1, ev(0, 0, 0, 0, 10, 1)});
        st.push_back('{5'b00000, 1'b0, 3'd1, ev(0, 0, 0, 0, 10, 1)});
        st.push_back('{5'b00001, 1'b1, 3'd0, ev(0, 0, 0, 0, 10, 1)});
        st.push_back('{5'b00000, 1'b1, 3'd2, ev(0, 0, 0, 0, 10, 1)});
        foreach (st[i]) begin
            drive(st[i].b, st[i].s, st[i].p, st[i].e);
            exp = sb_q.pop_front();
            checks++;
            if (obs() !== exp) begin
                fails++;
                $display("FAIL game_over step %0d: got %h expected %h", i, obs(), exp);
            end
        end
        apply_reset(5'b00000);
        drive(5'b00000, 1'b0, 3'd0, ev(0, 0, 0, 0, 0, 0));
        exp = sb_q.pop_front();
        checks++;
        if (obs() !== exp) begin
            fails++;
            $display("FAIL game_over_cleared: got %h expected %h", obs(), exp);
        end
    endtask

    initial begin
        bus.position_changed = 1'b0;
        bus.mole_position = 3'd0;
        test_reset();
        test_hit_and_miss();
        test_held_and_simultaneous();
        test_score_saturation();
        test_game_over();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
